// File: rtl/unsigned_mul_pkg.sv
// Shared types and constants for the FP multiply mantissa path.
package fpu_mul_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_e;

    localparam int unsigned MANT_W = 24;

    // Counter must hold the value N itself, hence one bit beyond clog2.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/unsigned_mul_if.sv
// Operand/product handshake bundle for the sequential unsigned multiplier.
interface unsigned_mul_if
    import fpu_mul_pkg::*;
#(
    parameter int unsigned N = MANT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   P;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/unsigned_mul_step.sv
// One radix-2 shift-add step: conditional add of the multiplicand, then shift right.
module unsigned_mul_step #(
    parameter int unsigned N = 24
) (
    input  logic [N-1:0]   hi,
    input  logic [N-1:0]   lo,
    input  logic [N-1:0]   mcand,
    output logic [2*N-1:0] next
);
    logic [N:0] sum;

    // The carry out of sum lands in the top bit of hi after the shift.
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        next = {sum, lo[N-1:1]};
    end
endmodule

// File: rtl/unsigned_mul.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// UNSIGNED_MUL_EARLY_TERM_EN finishes once the remaining multiplier bits are all zero.
module unsigned_mul
    import fpu_mul_pkg::*;
#(
    parameter int unsigned N = MANT_W
) (
    input logic           clk,
    input logic           rstn,
    unsigned_mul_if.slave bus
);
    localparam int unsigned CNT_W = cnt_w(N);

    mul_state_e       state_q, state_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;
    logic             out_valid_q, out_valid_d;
    logic [2*N-1:0]   step_next;
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
    logic [N-1:0]     mr_q, mr_d;
`endif

    unsigned_mul_step #(.N(N)) u_step (
        .hi    (hi_q),
        .lo    (lo_q),
        .mcand (mcand_q),
        .next  (step_next)
    );

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
        mr_d        = mr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = bus.A;
                    hi_d    = '0;
                    lo_d    = bus.B;
                    cnt_d   = CNT_W'(N);
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
                    mr_d    = bus.B;
`endif
                    state_d = CALC;
                end
            end
            CALC: begin
                {hi_d, lo_d} = step_next;
                cnt_d        = cnt_q - CNT_W'(1);
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
                mr_d         = mr_q >> 1;
                // Remaining steps would only add zero, so align the partial product now.
                if ((mr_q >> 1) == '0) begin
                    p_d         = step_next >> (cnt_q - CNT_W'(1));
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`else
                if (cnt_q == CNT_W'(1)) begin
                    p_d         = step_next;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= CNT_W'(N);
            p_q         <= '0;
            out_valid_q <= 1'b0;
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
            mr_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
            mr_q        <= mr_d;
`endif
        end
    end

    assign bus.in_ready  = rstn && (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.P         = p_q;

endmodule

// File: tb/tb_unsigned_mul.sv
// Randomised self-checking bench for unsigned_mul against an arithmetic reference model.
module tb_unsigned_mul;
    localparam int unsigned N = 24;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [2*N-1:0] exp_p = '0;
    bit             exp_live = 1'b0;

    unsigned_mul_if #(.N(N)) bus ();

    unsigned_mul #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic int model_latency(input logic [N-1:0] b);
`ifdef UNSIGNED_MUL_EARLY_TERM_EN
        int m = 0;
        for (int i = 0; i < int'(N); i++) if (b[i]) m = i;
        return m + 1;
`else
        return int'(N);
`endif
    endfunction

    // Product must equal the exact A*B of the accepted operands whenever it is presented.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && exp_live) check_eq("p_vs_model", bus.P, exp_p);
    end

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int stall,
                          input bit toggle, input bit use_lit, input logic [2*N-1:0] lit);
        int  t;
        int  edges;
        bit  seen;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
        bus.A         = a;
        bus.B         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        exp_p         = (2*N)'(a) * (2*N)'(b);
        exp_live      = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = toggle;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.out_valid) seen = 1'b1;
            else if (toggle) begin
                bus.A = N'($urandom);
                bus.B = N'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        check_eq("latency", 64'(edges), 64'(model_latency(b)));
        if (use_lit) check_eq("p_literal", bus.P, 64'(lit));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
            check_eq("hold_p", bus.P, exp_p);
            check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
            bus.in_valid = i[0];
            bus.A        = N'(7);
            bus.B        = N'(7);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("drain_valid", 64'(bus.out_valid), 64'd0);
        check_eq("drain_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_p", bus.P, 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        rstn = 1'b1;
        #1;
        check_eq("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_op(N'(3), N'(5), 0, 1'b0, 1'b1, 48'd15);
        run_op(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, 1'b1, 48'hFFFFFE000001);
        run_op(24'hC00000, 24'hC00000, 0, 1'b0, 1'b1, 48'h900000000000);
        run_op(N'(11), N'(13), 10, 1'b0, 1'b1, 48'd143);
        run_op(N'(2), N'(9), 0, 1'b0, 1'b1, 48'd18);

        // Abort an operation mid-CALC with an asynchronous reset.
        @(negedge clk);
        bus.A        = 24'h123456;
        bus.B        = 24'h654321;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check_eq("abort_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("abort_p", bus.P, 64'd0);
        check_eq("abort_in_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_eq("abort_release_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("abort_release_p", bus.P, 64'd0);
        run_op(N'(4), N'(4), 0, 1'b0, 1'b1, 48'd16);

        run_op(N'(10), N'(20), 0, 1'b1, 1'b1, 48'd200);

`ifdef UNSIGNED_MUL_EARLY_TERM_EN
        run_op(24'hABCDEF, 24'h000000, 0, 1'b0, 1'b1, 48'h0);
        run_op(24'h800000, 24'h000001, 0, 1'b0, 1'b1, 48'h800000);
        run_op(24'h000003, 24'h800000, 0, 1'b0, 1'b1, 48'h1800000);
        run_op(24'h000005, 24'h000010, 0, 1'b0, 1'b1, 48'h50);
`endif

        for (int k = 0; k < 25; k++) begin
            ra = N'($urandom);
            rb = N'($urandom) >> $urandom_range(0, N - 1);
            run_op(ra, rb, int'($urandom_range(0, 3)), k[2], 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
